seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised Moore serial-pattern detector, successor to the fixed 3-bit "101" detector.
- Pattern (1..PAT_W bits), pattern length and overlap mode are run-time programmable; input is qualified by a valid strobe.
- Keeps a saturating match counter.
- Sits on a serial bit stream (UART/line-decoder output) and flags each complete pattern occurrence to downstream control.

Parameters:
- PAT_W, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(PAT_W+1), width of the pattern-length field.
- CNT_W, 16, width of the match counter.
- DEF_PAT, 'b101 (zero-extended to PAT_W), pattern loaded at reset.
- DEF_LEN, 3, pattern length loaded at reset.
- DEF_OVL, 1, overlap mode loaded at reset.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- din_valid  in  1  din is sampled only when high.
- din  in  1  serial data bit.
- cfg_load  in  1  one-cycle strobe that latches cfg_pat, cfg_len and cfg_ovl.
- cfg_pat  in  PAT_W  pattern; bit cfg_len-1 is the first bit received, bit 0 the last.
- cfg_len  in  LEN_W  pattern length; legal range 1..PAT_W.
- cfg_ovl  in  1  1 = overlapping matches, 0 = non-overlapping.
- cnt_clr  in  1  clears match_count.
- dout  out  1  Moore match flag (high while FSM is in HIT).
- match_count  out  CNT_W  saturating count of matches.
- cfg_err  out  1  high while the active configuration is illegal.

Behaviour:
- Reset (rst=1 at posedge):
  - config <= DEF_PAT/DEF_LEN/DEF_OVL.
  - history <= 0, fill <= 0.
  - state <= SCAN.
  - dout=0, match_count=0, cfg_err=0.
  - Reset mid-stream discards all partial matches.
- Internal registers:
  - history[PAT_W-1:0]: shift register of accepted bits, new bit enters at bit 0.
  - fill: number of valid history bits, saturating at PAT_W.
  - mask: low cfg_len bits set.
- FSM states IDLE, SCAN, HIT. dout = (state==HIT), a decode of the registered state only, never of din.
  - IDLE: configuration illegal. cfg_err=1. Bits are ignored. Leaves IDLE only via a legal cfg_load or rst.
  - SCAN/HIT, accepted bit (din_valid=1):
    - hist_n = {history[PAT_W-2:0], din}, fill_n = min(fill+1, PAT_W).
    - Match when fill_n >= len AND (hist_n & mask) == (pat & mask).
    - Match -> state HIT, match_count+1.
    - No match -> state SCAN.
  - SCAN/HIT, din_valid=0: state, history, fill and dout all hold. A HIT persists across valid gaps.
- Overlap mode:
  - ovl=1: on a match, fill_n is kept, so the pattern suffix can start the next match (101 then 01 gives two hits).
  - ovl=0: on a match, fill <= 0 and history <= 0; the next match needs len fresh bits.
- Latency:
  - dout rises at the posedge that accepts the final pattern bit, i.e. it is visible the cycle after din is presented.
  - dout falls at the next accepted bit that does not complete a match.
  - Back-to-back matches keep dout high continuously; match_count shows each one.
- cfg_load:
  - Latches cfg_pat, cfg_len and cfg_ovl.
  - Clears history, fill and dout.
  - cfg_len==0 or cfg_len>PAT_W -> state IDLE, cfg_err=1; otherwise state SCAN, cfg_err=0.
  - match_count is unaffected.
- Simultaneous events, in priority order:
  - rst > cfg_load > din_valid. A bit presented in the same cycle as cfg_load is dropped.
  - cnt_clr together with a match -> match_count=1.
  - cnt_clr without a match -> 0.
- Counter saturates at 2^CNT_W-1; further matches still raise dout.
- Expected RTL size: ~150-250 lines.

Decomposition:
- Package seq_det_pkg:
  - state enum (IDLE=2'd0, SCAN=2'd1, HIT=2'd2).
  - LEN_W computation function.
  - default pattern constants.
- Sub-module sat_counter (parameter W; inputs clr and inc; output count). Reused by the other counters in the codebase.
- Matcher logic (mask, compare) stays in the top module.

Test Plan:
- Defaults, stream 1,0,1,0,1 all valid -> dout high after bits 3 and 5, low after bit 4; match_count=2.
- cfg_load pat=101, len=3, ovl=0, same stream -> dout high after bit 3 only; match_count=1.
- cfg_load pat=8'b11010011, len=8, stream 0,1,1,0,1,0,0,1,1 -> dout rises after the 9th bit; din_valid low 5 cycles -> dout holds; next bit 0 -> dout low.
- cfg_load len=0 -> cfg_err=1, dout stays 0 for any stream; cfg_load len=2, pat=11 -> cfg_err=0; stream 1,1,1 -> 2 matches.
- CNT_W=2, defaults, stream 1,0,1,0,1,0,1,0,1 -> match_count sticks at 3 and dout still pulses; cnt_clr coinciding with a match -> match_count=1.
- rst asserted after bits 1,0 of "101", then stream 1 -> no match; a fresh full 1,0,1 is needed for dout.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the parametrised serial-pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HIT  = 2'd2
    } state_t;

    localparam logic [2:0] DEF_PATTERN = 3'b101;
    localparam int         DEF_LENGTH  = 3;
    localparam bit         DEF_OVERLAP = 1'b1;

    // Length field must be able to hold PAT_W itself, not just PAT_W-1.
    function automatic int calc_len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment leaves the counter at one.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial-pattern detector with run-time programmable pattern, length
// and overlap mode, plus a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 8,
    parameter int               LEN_W   = calc_len_w(PAT_W),
    parameter int               CNT_W   = 16,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PATTERN),
    parameter logic [LEN_W-1:0] DEF_LEN = LEN_W'(DEF_LENGTH),
    parameter logic             DEF_OVL = DEF_OVERLAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_ovl,
    input  logic             cnt_clr,
    output logic             dout,
    output logic [CNT_W-1:0] match_count,
    output logic             cfg_err
);

    localparam logic [LEN_W-1:0] PAT_MAX = LEN_W'(PAT_W);

    state_t           state;
    logic [PAT_W-1:0] pat_r;
    logic [LEN_W-1:0] len_r;
    logic             ovl_r;
    logic [PAT_W-1:0] history;
    logic [LEN_W-1:0] fill;

    logic [PAT_W-1:0] mask;
    logic [PAT_W-1:0] hist_n;
    logic [LEN_W-1:0] fill_n;
    logic             hit_n;
    logic             accept;
    logic             match;
    logic             cfg_legal;

    // Next-history candidate and pattern compare over the active length only.
    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            if (i < int'(len_r)) begin
                mask[i] = 1'b1;
            end
        end
        hist_n = (history << 1) | PAT_W'(din);
        fill_n = (fill == PAT_MAX) ? fill : fill + LEN_W'(1);
        hit_n  = (fill_n >= len_r) && (((hist_n ^ pat_r) & mask) == '0);
    end

    // A bit sharing its cycle with cfg_load is dropped.
    assign accept    = din_valid && !cfg_load && (state != IDLE);
    assign match     = accept && hit_n;
    assign cfg_legal = (cfg_len != '0) && (cfg_len <= PAT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_r   <= DEF_PAT;
            len_r   <= DEF_LEN;
            ovl_r   <= DEF_OVL;
            history <= '0;
            fill    <= '0;
            state   <= SCAN;
        end else if (cfg_load) begin
            pat_r   <= cfg_pat;
            len_r   <= cfg_len;
            ovl_r   <= cfg_ovl;
            history <= '0;
            fill    <= '0;
            state   <= cfg_legal ? SCAN : IDLE;
        end else if (accept) begin
            if (hit_n) begin
                state <= HIT;
                if (ovl_r) begin
                    history <= hist_n;
                    fill    <= fill_n;
                end else begin
                    history <= '0;
                    fill    <= '0;
                end
            end else begin
                state   <= SCAN;
                history <= hist_n;
                fill    <= fill_n;
            end
        end
    end

    assign dout    = (state == HIT);
    assign cfg_err = (state == IDLE);

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (match),
        .count(match_count)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param; a second instance with
// a 2-bit counter exercises saturation.
module tb_seq_detector_param;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             din_valid;
    logic             din;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_ovl;
    logic             cnt_clr;
    logic             dout;
    logic [15:0]      match_count;
    logic             cfg_err;
    logic             dout2;
    logic [1:0]       match_count2;
    logic             cfg_err2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(PAT_W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr), .dout(dout),
        .match_count(match_count), .cfg_err(cfg_err)
    );

    seq_detector_param #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr), .dout(dout2),
        .match_count(match_count2), .cfg_err(cfg_err2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic v, input logic b, input logic clr);
        din_valid = v;
        din       = b;
        cnt_clr   = clr;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = 1'b0;
        cnt_clr   = 1'b0;
    endtask

    task automatic loadCfg(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        cfg_pat  = p;
        cfg_len  = l;
        cfg_ovl  = o;
        cfg_load = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Bit n-1 of bits is sent first; exp holds the expected dout after each bit.
    task automatic runStream(input string tag, input int n, input logic [15:0] bits, input logic [15:0] exp);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(1'b1, bits[i], 1'b0);
            checkOutput($sformatf("%s_dout_b%0d", tag, n - i), 32'(dout), 32'(exp[i]));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; din_valid = 1'b0; din = 1'b0; cfg_load = 1'b0;
        cfg_pat = '0; cfg_len = '0; cfg_ovl = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("rst_dout", 32'(dout), 32'd0);
        checkOutput("rst_cnt", 32'(match_count), 32'd0);
        checkOutput("rst_err", 32'(cfg_err), 32'd0);
        checkOutput("rst_cnt2", 32'(match_count2), 32'd0);

        $display("[TB] defaults, overlapping 101");
        runStream("ovl", 5, 16'b10101, 16'b00101);
        checkOutput("ovl_cnt", 32'(match_count), 32'd2);

        $display("[TB] non-overlapping 101");
        loadCfg(8'b101, 4'd3, 1'b0);
        checkOutput("load_keeps_cnt", 32'(match_count), 32'd2);
        checkOutput("load_dout", 32'(dout), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("clr_cnt", 32'(match_count), 32'd0);
        runStream("novl", 5, 16'b10101, 16'b00100);
        checkOutput("novl_cnt", 32'(match_count), 32'd1);

        $display("[TB] full-width pattern with valid gap");
        loadCfg(8'b11010011, 4'd8, 1'b1);
        runStream("w8", 9, 16'b011010011, 16'b000000001);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("w8_gap%0d", i), 32'(dout), 32'd1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("w8_fall", 32'(dout), 32'd0);
        checkOutput("w8_cnt", 32'(match_count), 32'd2);

        $display("[TB] illegal and short configurations");
        loadCfg(8'b0, 4'd0, 1'b1);
        checkOutput("len0_err", 32'(cfg_err), 32'd1);
        runStream("len0", 3, 16'b101, 16'b000);
        checkOutput("len0_cnt", 32'(match_count), 32'd2);
        loadCfg(8'hFF, 4'd9, 1'b1);
        checkOutput("len9_err", 32'(cfg_err), 32'd1);
        loadCfg(8'b11, 4'd2, 1'b1);
        checkOutput("len2_err", 32'(cfg_err), 32'd0);
        runStream("len2", 3, 16'b111, 16'b011);
        checkOutput("len2_cnt", 32'(match_count), 32'd4);

        $display("[TB] counter saturation");
        doReset();
        checkOutput("sat_rst_cnt2", 32'(match_count2), 32'd0);
        runStream("sat", 9, 16'b101010101, 16'b001010101);
        checkOutput("sat_cnt", 32'(match_count), 32'd4);
        checkOutput("sat_cnt2", 32'(match_count2), 32'd3);
        checkOutput("sat_dout2", 32'(dout2), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("sat_dout2_low", 32'(dout2), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("clrhit_cnt", 32'(match_count), 32'd1);
        checkOutput("clrhit_cnt2", 32'(match_count2), 32'd1);
        checkOutput("clrhit_dout2", 32'(dout2), 32'd1);

        $display("[TB] reset discards partial match");
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        doReset();
        runStream("rstmid", 3, 16'b101, 16'b001);
        checkOutput("rstmid_cnt", 32'(match_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
